// File: rtl/nn_loader_pkg.sv
// Shared target codes, loader states and length-field sizing for nn_param_loader.
package nn_loader_pkg;

    localparam int LEN_BYTES_DEF = 2;
    localparam int LEN_W         = 8 * LEN_BYTES_DEF;
    localparam int NUM_TGT       = 6;

    localparam logic [2:0] TGT_W          = 3'd0;
    localparam logic [2:0] TGT_BETA_SHIFT = 3'd1;
    localparam logic [2:0] TGT_MINUS_TETA = 3'd2;
    localparam logic [2:0] TGT_BN_FACTOR  = 3'd3;
    localparam logic [2:0] TGT_BN_ADDEND  = 3'd4;
    localparam logic [2:0] TGT_INPUTS     = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        FETCH,
        SHIFT,
        CSUM
    } state_e;

endpackage

// File: rtl/nn_symbol_shifter.sv
// Holds one payload byte and steps through it LSB-first, PAR_W bits per symbol
// (or the whole byte in wide mode); last flags the byte's final symbol.
module nn_symbol_shifter
    import nn_loader_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int PAR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic              wide,
    input  logic [IN_W-1:0]   ld_dat,
    output logic [PAR_W-1:0]  sym_par,
    output logic [IN_W-1:0]   sym_byte,
    output logic              last
);
    localparam int SYMS  = IN_W / PAR_W;
    localparam int IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;

    logic [IN_W-1:0]  dat_q, dat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wide_q, wide_d;

    always_comb begin
        dat_d  = dat_q;
        idx_d  = idx_q;
        wide_d = wide_q;
        if (load) begin
            dat_d  = ld_dat;
            idx_d  = '0;
            wide_d = wide;
        end else if (advance) begin
            dat_d = dat_q >> PAR_W;
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q  <= '0;
            idx_q  <= '0;
            wide_q <= 1'b0;
        end else begin
            dat_q  <= dat_d;
            idx_q  <= idx_d;
            wide_q <= wide_d;
        end
    end

    assign sym_par  = dat_q[PAR_W-1:0];
    assign sym_byte = dat_q;
    assign last     = wide_q || (idx_q == IDX_W'(SYMS - 1));

endmodule

// File: rtl/nn_param_loader.sv
// Framed byte stream -> one symbol per cycle into the selected SIPO chain; first CE one cycle after
// the first payload byte, gapless while bytes keep coming; in_ready only where a byte can be taken.
// NN_PARAM_LOADER_CHECKSUM_EN adds a trailing checksum byte per frame.
module nn_param_loader
    import nn_loader_pkg::*;
#(
    parameter int LEN_BYTES = LEN_BYTES_DEF,
    parameter int IN_W      = 8,
    parameter int PAR_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PAR_W-1:0]  nn_parameters,
    output logic [IN_W-1:0]   inputs,
    output logic              fifo_w_ce,
    output logic              fifo_beta_shift_ce,
    output logic              fifo_minus_teta_ce,
    output logic              fifo_BN_factor_ce,
    output logic              fifo_BN_addend_ce,
    output logic              fifo_inputs_ce,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              clr_err
);
    localparam int LW   = 8 * LEN_BYTES;
    localparam int LB_W = $clog2(LEN_BYTES + 1);

    state_e               state_q, state_d;
    logic [2:0]           tgt_q, tgt_d;
    logic [LW-1:0]        len_q, len_d, rem_q, rem_d;
    logic [LB_W-1:0]      lb_q, lb_d;
    logic [NUM_TGT-1:0]   ce_q, ce_d;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                 rdy, xfer, tgt_ok, byte_last, payload_end;
    logic                 sh_load, sh_adv, sh_last;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
    logic [IN_W-1:0]      sum_q, sum_d, sum_chk;
`endif

    nn_symbol_shifter #(.IN_W(IN_W), .PAR_W(PAR_W)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .advance  (sh_adv),
        .wide     (tgt_q == TGT_INPUTS),
        .ld_dat   (in_data),
        .sym_par  (nn_parameters),
        .sym_byte (inputs),
        .last     (sh_last)
    );

    // Invalid targets never load the shifter; each drained byte counts as one symbol.
    always_comb begin
        tgt_ok    = (tgt_q <= TGT_INPUTS);
        byte_last = sh_last || !tgt_ok;
        rdy       = (state_q == SHIFT) ? (byte_last && (rem_q != '0)) : 1'b1;
        xfer      = in_valid && rdy;
    end

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        len_d       = len_q;
        rem_d       = rem_q;
        lb_d        = lb_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = clr_err ? 1'b0 : err_q;
        sh_load     = 1'b0;
        sh_adv      = 1'b0;
        payload_end = 1'b0;
        ce_d        = '0;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        sum_chk     = sum_q + in_data;
`endif
        unique case (state_q)
            IDLE: if (xfer) begin
                tgt_d   = in_data[2:0];
                lb_d    = '0;
                busy_d  = 1'b1;
                state_d = LEN;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
                sum_d   = '0;
`endif
                if (in_data[2:0] > TGT_INPUTS) err_d = 1'b1;
            end
            LEN: if (xfer) begin
                len_d = (len_q >> 8) | (LW'(in_data[7:0]) << (LW - 8));
                lb_d  = lb_q + 1'b1;
                if (lb_q == LB_W'(LEN_BYTES - 1)) begin
                    rem_d = len_d;
                    if (len_d == '0) payload_end = 1'b1;
                    else             state_d     = FETCH;
                end
            end
            FETCH: if (xfer) begin
                sh_load = tgt_ok;
                rem_d   = rem_q - 1'b1;
                state_d = SHIFT;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
                sum_d   = sum_chk;
`endif
            end
            SHIFT: begin
                if (rem_q == '0) begin
                    payload_end = 1'b1;
                end else if (!byte_last) begin
                    sh_adv = 1'b1;
                    rem_d  = rem_q - 1'b1;
                end else if (xfer) begin
                    sh_load = tgt_ok;
                    rem_d   = rem_q - 1'b1;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
                    sum_d   = sum_chk;
`endif
                end else begin
                    state_d = FETCH;
                end
            end
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
            CSUM: if (xfer) begin
                if (sum_chk != '0) err_d = 1'b1;
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (payload_end) begin
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
        end

        if (state_d == SHIFT && tgt_ok) ce_d[tgt_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            lb_q    <= '0;
            ce_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            lb_q    <= lb_d;
            ce_q    <= ce_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign in_ready           = rdy && !rst;
    assign fifo_w_ce          = ce_q[TGT_W];
    assign fifo_beta_shift_ce = ce_q[TGT_BETA_SHIFT];
    assign fifo_minus_teta_ce = ce_q[TGT_MINUS_TETA];
    assign fifo_BN_factor_ce  = ce_q[TGT_BN_FACTOR];
    assign fifo_BN_addend_ce  = ce_q[TGT_BN_ADDEND];
    assign fifo_inputs_ce     = ce_q[TGT_INPUTS];
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;

endmodule
